// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Provides address/instruction widths, boolean and null constants, the
// fetch FSM state encoding and a word-alignment helper.
package instr_fetch_pkg;

  localparam int          ADDR_W   = 32;
  localparam int          INSTRLEN = 32;
  localparam logic        TRUE     = 1'b1;
  localparam logic        FALSE    = 1'b0;
  localparam logic [31:0] NULL32   = 32'h0000_0000;

  typedef enum logic [0:0] {
    IF_FETCH = 1'b0,
    IF_MISS  = 1'b1
  } if_state_e;

  // Instructions are word aligned; the two low address bits never select anything.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bus bundle around the fetch unit: decoder handshake (IF_success, instr,
// fetch_pc, stall_RS), ROB redirect (flush, flush_pc) and the memory
// controller word-fetch channel (mc_req_*, mc_resp_*).
// master = fetch unit side, slave = decoder/ROB/memory controller side.
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic                IF_success;
  logic [INSTRLEN-1:0] instr;
  logic [ADDR_W-1:0]   fetch_pc;
  logic                stall_RS;
  logic                flush;
  logic [ADDR_W-1:0]   flush_pc;
  logic                mc_req_valid;
  logic [ADDR_W-1:0]   mc_req_addr;
  logic                mc_resp_valid;
  logic [INSTRLEN-1:0] mc_resp_data;

  modport master (
    output IF_success, instr, fetch_pc, mc_req_valid, mc_req_addr,
    input  stall_RS, flush, flush_pc, mc_resp_valid, mc_resp_data
  );

  modport slave (
    input  IF_success, instr, fetch_pc, mc_req_valid, mc_req_addr,
    output stall_RS, flush, flush_pc, mc_resp_valid, mc_resp_data
  );

endinterface

// File: rtl/instr_fetch_icache_dm.sv
// Direct-mapped, one-word-per-line instruction cache storage.
// Ports:
//   clk              clock
//   clr_n            synchronous active-low clear of all valid bits
//   rd_idx/rd_tag    lookup address split; rd_hit/rd_data are combinational
//   wr_en/wr_idx/wr_tag/wr_data  synchronous line fill
module instr_fetch_icache_dm #(
  parameter int IDX_W  = 6,
  parameter int TAG_W  = 24,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic              rd_hit,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0]  valid_r;
  logic [TAG_W-1:0]  tag_r  [DEPTH];
  logic [DATA_W-1:0] data_r [DEPTH];

  // Valid bits: cleared only by reset, set by a fill
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      valid_r <= {DEPTH{1'b0}};
    end else if (wr_en) begin
      valid_r[wr_idx] <= 1'b1;
    end
  end

  // Tag and data arrays need no reset since valid gates their use
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_r[wr_idx]  <= wr_tag;
      data_r[wr_idx] <= wr_data;
    end
  end

  assign rd_hit  = valid_r[rd_idx] && (tag_r[rd_idx] == rd_tag);
  assign rd_data = data_r[rd_idx];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: holds the PC, looks up a direct-mapped
// I-cache, fetches missing words from the memory controller and presents
// one instruction per cycle to the decoder with stall_RS back-pressure.
// A ROB flush redirects the PC; a flush during a miss lets the fill
// complete but suppresses its presentation (drop).
// Ports:
//   clk   clock
//   rst   synchronous active-low reset
//   rdy   global ready; 0 freezes all state and ignores all inputs
//   bus   instr_fetch_if.master (decoder, ROB redirect, memory controller)
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int          ICACHE_IDX_W = 6,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst,
  input logic           rdy,
  instr_fetch_if.master bus
);

  localparam int TAG_W = ADDR_W - ICACHE_IDX_W - 2;

  if_state_e           state_r, state_s;
  logic [ADDR_W-1:0]   pc_r, pc_s;
  logic                drop_r, drop_s;
  logic                if_success_r, if_success_s;
  logic [INSTRLEN-1:0] instr_r, instr_s;
  logic [ADDR_W-1:0]   fetch_pc_r, fetch_pc_s;
  logic                req_valid_r, req_valid_s;
  logic [ADDR_W-1:0]   req_addr_r, req_addr_s;

  logic                hit_s;
  logic [INSTRLEN-1:0] hit_data_s;
  logic                fill_en_s;
  logic                fill_go_s;
  logic                slot_free_s;

  // A fill only lands when the edge is actually taken (ready, not in reset)
  assign fill_go_s   = fill_en_s && rdy && rst;
  assign slot_free_s = !if_success_r || !bus.stall_RS;

  instr_fetch_icache_dm #(
    .IDX_W  (ICACHE_IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (INSTRLEN)
  ) u_icache (
    .clk     (clk),
    .clr_n   (rst),
    .rd_idx  (pc_r[ICACHE_IDX_W+1:2]),
    .rd_tag  (pc_r[ADDR_W-1:ICACHE_IDX_W+2]),
    .rd_hit  (hit_s),
    .rd_data (hit_data_s),
    .wr_en   (fill_go_s),
    .wr_idx  (req_addr_r[ICACHE_IDX_W+1:2]),
    .wr_tag  (req_addr_r[ADDR_W-1:ICACHE_IDX_W+2]),
    .wr_data (bus.mc_resp_data)
  );

  // Next-state, PC, miss-request and decoder output-slot logic
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    drop_s       = drop_r;
    if_success_s = if_success_r;
    instr_s      = instr_r;
    fetch_pc_s   = fetch_pc_r;
    req_valid_s  = req_valid_r;
    req_addr_s   = req_addr_r;
    fill_en_s    = FALSE;

    if (bus.flush) begin
      // Redirect wins over any hit or response this cycle
      pc_s         = word_align(bus.flush_pc);
      if_success_s = FALSE;
      if (state_r == IF_MISS) begin
        if (bus.mc_resp_valid) begin
          fill_en_s   = TRUE;
          req_valid_s = FALSE;
          state_s     = IF_FETCH;
          drop_s      = FALSE;
        end else begin
          // Outstanding request cannot be cancelled; discard its word later
          drop_s = TRUE;
        end
      end else begin
        state_s = IF_FETCH;
      end
    end else begin
      case (state_r)
        IF_FETCH: begin
          if (slot_free_s) begin
            if (hit_s) begin
              if_success_s = TRUE;
              instr_s      = hit_data_s;
              fetch_pc_s   = pc_r;
              pc_s         = pc_r + 32'd4;
            end else begin
              req_valid_s  = TRUE;
              req_addr_s   = word_align(pc_r);
              state_s      = IF_MISS;
              if_success_s = FALSE;
            end
          end else begin
            state_s = IF_FETCH;
          end
        end
        IF_MISS: begin
          if (bus.mc_resp_valid) begin
            fill_en_s   = TRUE;
            req_valid_s = FALSE;
            state_s     = IF_FETCH;
            if (drop_r) begin
              drop_s       = FALSE;
              if_success_s = FALSE;
            end else begin
              if_success_s = TRUE;
              instr_s      = bus.mc_resp_data;
              fetch_pc_s   = pc_r;
              pc_s         = pc_r + 32'd4;
            end
          end else begin
            state_s = IF_MISS;
          end
        end
        default: begin
          state_s = IF_FETCH;
        end
      endcase
    end
  end

  // State, PC and output registers; rdy low freezes everything
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= IF_FETCH;
      pc_r         <= RESET_PC;
      drop_r       <= FALSE;
      if_success_r <= FALSE;
      instr_r      <= NULL32;
      fetch_pc_r   <= NULL32;
      req_valid_r  <= FALSE;
      req_addr_r   <= NULL32;
    end else if (rdy) begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      drop_r       <= drop_s;
      if_success_r <= if_success_s;
      instr_r      <= instr_s;
      fetch_pc_r   <= fetch_pc_s;
      req_valid_r  <= req_valid_s;
      req_addr_r   <= req_addr_s;
    end
  end

  assign bus.IF_success   = if_success_r;
  assign bus.instr        = instr_r;
  assign bus.fetch_pc     = fetch_pc_r;
  assign bus.mc_req_valid = req_valid_r;
  assign bus.mc_req_addr  = req_addr_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a directed vector table for the cold start, warm
// loop, stall, flush/miss interactions, rdy freeze, aliasing, reset and PC
// wrap, then a randomized run checked against a program-order scoreboard
// plus a per-index residency model of the cache.
module tb_instr_fetch;

  logic clk;
  logic rst;
  logic rdy;
  int   nchk;
  int   nerr;

  instr_fetch_if bus();

  instr_fetch dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst_n;
    bit          rdy;
    bit          stall;
    bit          flush;
    logic [31:0] fpc;
    bit          rv;
    logic [31:0] rd;
    bit          e_ifs;
    logic [31:0] e_instr;
    logic [31:0] e_fpc;
    bit          e_reqv;
    logic [31:0] e_reqa;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(bit r, bit y, bit s, bit f, logic [31:0] fp, bit rv,
                               logic [31:0] rd, bit ei, logic [31:0] einstr,
                               logic [31:0] efpc, bit eq, logic [31:0] ea);
    vec_t v;
    v.rst_n = r; v.rdy = y; v.stall = s; v.flush = f; v.fpc = fp; v.rv = rv; v.rd = rd;
    v.e_ifs = ei; v.e_instr = einstr; v.e_fpc = efpc; v.e_reqv = eq; v.e_reqa = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory image used by the randomized phase
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Which word address currently occupies each of the 64 cache slots
  bit          res_v    [64];
  logic [31:0] res_addr [64];

  function automatic bit resident(input logic [31:0] a);
    return res_v[a[7:2]] && (res_addr[a[7:2]] == a);
  endfunction

  task automatic drive(input bit r, input bit y, input bit s, input bit f,
                       input logic [31:0] fp, input bit rv, input logic [31:0] rd);
    rst = r; rdy = y; bus.stall_RS = s; bus.flush = f; bus.flush_pc = fp;
    bus.mc_resp_valid = rv; bus.mc_resp_data = rd;
  endtask

  initial begin
    logic        ifs, reqv, p_ifs, p_reqv, p_rdy, p_hold, p_flush, p_resp, fresh;
    logic [31:0] ins, fpc, reqa, p_ins, p_fpc, p_reqa, exp_pc;
    logic        d_rdy, d_stall, d_flush, d_rv;
    logic [31:0] d_fpc, d_rd;
    int          lat, npresent;

    nchk = 0;
    nerr = 0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // ---------------- directed vector table ----------------
    vecs.push_back(mkv(0,1,0,0,32'h0,0,32'h0,        0,32'h0,0,0,32'h0));
    vecs.push_back(mkv(0,1,0,0,32'h0,0,32'h0,        0,32'h0,0,0,32'h0));
    vecs.push_back(mkv(1,1,0,0,32'h0,0,32'h0,        0,32'h0,0,1,32'h0));
    vecs.push_back(mkv(1,1,0,0,32'h0,0,32'h0,        0,32'h0,0,1,32'h0));
    vecs.push_back(mkv(1,1,0,0,32'h0,1,32'h00500093, 1,32'h00500093,32'h0,0,32'h0));
    vecs.push_back(mkv(1,1,0,0,32'h0,0,32'h0,        0,32'h0,0,1,32'h4));
    vecs.push_back(mkv(1,1,0,0,32'h0,1,32'h11111111, 1,32'h11111111,32'h4,0,32'h0));
    vecs.push_back(mkv(1,1,1,0,32'h0,0,32'h0,        1,32'h11111111,32'h4,0,32'h0));
    vecs.push_back(mkv(1,0,0,0,32'h0,1,32'hAAAAAAAA, 1,32'h11111111,32'h4,0,32'h0));
    vecs.push_back(mkv(1,1,0,0,32'h0,0,32'h0,        0,32'h0,0,1,32'h8));
    vecs.push_back(mkv(1,0,0,0,32'h0,1,32'hBBBBBBBB, 0,32'h0,0,1,32'h8));
    vecs.push_back(mkv(1,0,0,0,32'h0,1,32'hBBBBBBBB, 0,32'h0,0,1,32'h8));
    vecs.push_back(mkv(1,1,0,0,32'h0,1,32'h22222222, 1,32'h22222222,32'h8,0,32'h0));
    vecs.push_back(mkv(1,1,0,0,32'h0,0,32'h0,        0,32'h0,0,1,32'hC));
    vecs.push_back(mkv(1,1,0,0,32'h0,1,32'h33333333, 1,32'h33333333,32'hC,0,32'h0));
    vecs.push_back(mkv(1,1,0,1,32'h0,0,32'h0,        0,32'h0,0,0,32'h0));
    vecs.push_back(mkv(1,1,0,0,32'h0,0,32'h0,        1,32'h00500093,32'h0,0,32'h0));
    vecs.push_back(mkv(1,1,0,0,32'h0,0,32'h0,        1,32'h11111111,32'h4,0,32'h0));
    vecs.push_back(mkv(1,1,0,0,32'h0,0,32'h0,        1,32'h22222222,32'h8,0,32'h0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mkv(1,1,1,0,32'h0,0,32'h0,      1,32'h22222222,32'h8,0,32'h0));
    vecs.push_back(mkv(1,1,0,0,32'h0,0,32'h0,        1,32'h33333333,32'hC,0,32'h0));
    vecs.push_back(mkv(1,1,0,0,32'h0,0,32'h0,        0,32'h0,0,1,32'h10));
    vecs.push_back(mkv(1,1,0,1,32'h100,0,32'h0,      0,32'h0,0,1,32'h10));
    vecs.push_back(mkv(1,1,0,0,32'h0,1,32'h44444444, 0,32'h0,0,0,32'h0));
    vecs.push_back(mkv(1,1,0,0,32'h0,0,32'h0,        0,32'h0,0,1,32'h100));
    vecs.push_back(mkv(1,1,0,0,32'h0,1,32'h55555555, 1,32'h55555555,32'h100,0,32'h0));
    vecs.push_back(mkv(1,1,0,1,32'h10,0,32'h0,       0,32'h0,0,0,32'h0));
    vecs.push_back(mkv(1,1,0,0,32'h0,0,32'h0,        1,32'h44444444,32'h10,0,32'h0));
    vecs.push_back(mkv(1,1,0,1,32'h0,0,32'h0,        0,32'h0,0,0,32'h0));
    vecs.push_back(mkv(1,1,0,0,32'h0,0,32'h0,        0,32'h0,0,1,32'h0));
    vecs.push_back(mkv(1,1,0,1,32'h8,1,32'h00500093, 0,32'h0,0,0,32'h0));
    vecs.push_back(mkv(1,1,0,0,32'h0,0,32'h0,        1,32'h22222222,32'h8,0,32'h0));
    vecs.push_back(mkv(1,1,0,1,32'h0,0,32'h0,        0,32'h0,0,0,32'h0));
    vecs.push_back(mkv(1,1,0,0,32'h0,0,32'h0,        1,32'h00500093,32'h0,0,32'h0));
    vecs.push_back(mkv(1,1,0,1,32'hC,0,32'h0,        0,32'h0,0,0,32'h0));
    vecs.push_back(mkv(1,1,0,0,32'h0,0,32'h0,        1,32'h33333333,32'hC,0,32'h0));
    vecs.push_back(mkv(1,1,0,1,32'h200,0,32'h0,      0,32'h0,0,0,32'h0));
    vecs.push_back(mkv(1,1,0,0,32'h0,0,32'h0,        0,32'h0,0,1,32'h200));
    vecs.push_back(mkv(0,1,0,0,32'h0,0,32'h0,        0,32'h0,0,0,32'h0));
    vecs.push_back(mkv(1,1,0,0,32'h0,1,32'hDEADBEEF, 0,32'h0,0,1,32'h0));
    vecs.push_back(mkv(1,1,0,0,32'h0,1,32'h00500093, 1,32'h00500093,32'h0,0,32'h0));
    vecs.push_back(mkv(1,1,0,0,32'h0,0,32'h0,        0,32'h0,0,1,32'h4));
    vecs.push_back(mkv(1,1,0,0,32'h0,1,32'h11111111, 1,32'h11111111,32'h4,0,32'h0));
    vecs.push_back(mkv(1,1,0,1,32'hFFFFFFFC,0,32'h0, 0,32'h0,0,0,32'h0));
    vecs.push_back(mkv(1,1,0,0,32'h0,0,32'h0,        0,32'h0,0,1,32'hFFFFFFFC));
    vecs.push_back(mkv(1,1,0,0,32'h0,1,32'h66666666, 1,32'h66666666,32'hFFFFFFFC,0,32'h0));
    vecs.push_back(mkv(1,1,0,0,32'h0,0,32'h0,        1,32'h00500093,32'h0,0,32'h0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].rdy, vecs[i].stall, vecs[i].flush,
            vecs[i].fpc, vecs[i].rv, vecs[i].rd);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d IF_success", i), {31'd0, bus.IF_success}, {31'd0, vecs[i].e_ifs});
      chk($sformatf("v%0d mc_req_valid", i), {31'd0, bus.mc_req_valid}, {31'd0, vecs[i].e_reqv});
      if (vecs[i].e_ifs || !vecs[i].rst_n) begin
        chk($sformatf("v%0d instr", i), bus.instr, vecs[i].e_instr);
        chk($sformatf("v%0d fetch_pc", i), bus.fetch_pc, vecs[i].e_fpc);
      end
      if (vecs[i].e_reqv || !vecs[i].rst_n)
        chk($sformatf("v%0d mc_req_addr", i), bus.mc_req_addr, vecs[i].e_reqa);
    end

    // ---------------- randomized run vs scoreboard ----------------
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 64; k++) res_v[k] = 1'b0;
    exp_pc = 32'h0; lat = 1; npresent = 0;
    p_ifs = 1'b0; p_reqv = 1'b0; p_rdy = 1'b1; p_hold = 1'b0; p_flush = 1'b0; p_resp = 1'b0;
    p_ins = 32'h0; p_fpc = 32'h0; p_reqa = 32'h0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      ifs = bus.IF_success; ins = bus.instr; fpc = bus.fetch_pc;
      reqv = bus.mc_req_valid; reqa = bus.mc_req_addr;
      fresh = ifs && !(p_ifs && p_hold);

      if (p_ifs && p_hold) begin
        chk("rnd hold ifs", {31'd0, ifs}, 32'd1);
        chk("rnd hold fpc", fpc, p_fpc);
        chk("rnd hold instr", ins, p_ins);
      end
      if (!p_rdy) begin
        chk("rnd freeze reqv", {31'd0, reqv}, {31'd0, p_reqv});
        if (p_reqv) chk("rnd freeze reqa", reqa, p_reqa);
      end
      if (p_flush) chk("rnd flush no present", {31'd0, ifs}, 32'd0);
      if (fresh) begin
        npresent++;
        chk("rnd order fpc", fpc, exp_pc);
        chk("rnd instr", ins, mem_word(fpc));
        if (!p_resp) chk("rnd hit resident", {31'd0, resident(fpc)}, 32'd1);
      end
      if (reqv && !p_reqv) begin
        chk("rnd req addr", reqa, exp_pc);
        chk("rnd req not resident", {31'd0, resident(reqa)}, 32'd0);
      end
      if (p_rdy && p_reqv && !p_resp) begin
        chk("rnd req held", {31'd0, reqv}, 32'd1);
        chk("rnd req addr held", reqa, p_reqa);
      end
      if (p_resp) chk("rnd req dropped", {31'd0, reqv}, 32'd0);

      d_rdy   = ($urandom_range(0, 9) != 0);
      d_stall = ($urandom_range(0, 3) == 0);
      d_flush = ($urandom_range(0, 15) == 0);
      d_fpc   = 32'($urandom_range(0, 127)) << 2;
      if (reqv) begin
        if (lat == 0) begin
          d_rv = 1'b1; d_rd = mem_word(reqa); lat = $urandom_range(0, 3);
        end else begin
          d_rv = 1'b0; d_rd = 32'h0; lat--;
        end
      end else begin
        d_rv = ($urandom_range(0, 7) == 0); d_rd = $urandom;
      end
      drive(1'b1, d_rdy, d_stall, d_flush, d_fpc, d_rv, d_rd);

      p_resp = d_rdy && d_rv && reqv;
      if (p_resp) begin
        res_v[reqa[7:2]]    = 1'b1;
        res_addr[reqa[7:2]] = reqa;
      end
      if (d_rdy) begin
        if (d_flush) exp_pc = d_fpc;
        else if (ifs && !d_stall) exp_pc = exp_pc + 32'd4;
      end
      p_hold  = !d_rdy || (d_stall && !d_flush);
      p_flush = d_rdy && d_flush;
      p_rdy   = d_rdy;
      p_ifs = ifs; p_ins = ins; p_fpc = fpc; p_reqv = reqv; p_reqa = reqa;
    end
    chk("rnd progress", {31'd0, (npresent >= 50)}, 32'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
